// File: rtl/sar_searcher_if.sv
// ---------------------------------------------------------------------------
// sar_searcher_if
// Bundle between the successive-approximation searcher and its environment
// (the signed less-than comparator plus whoever requests searches).
//
//   start  : request a new search (environment -> searcher)
//   lt_in  : comparator answer, 1 = target < guess, signed (env -> searcher)
//   guess  : trial value presented to comparator input B (searcher -> env)
//   busy   : high while trial values are being presented (searcher -> env)
//   done   : one-cycle pulse when result becomes valid (searcher -> env)
//   result : found target value, signed (searcher -> env)
//
// master : the searcher itself
// slave  : the environment (comparator + requester)
// ---------------------------------------------------------------------------
interface sar_searcher_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             lt_in;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        input  start,
        input  lt_in,
        output guess,
        output busy,
        output done,
        output result
    );

    modport slave (
        output start,
        output lt_in,
        input  guess,
        input  busy,
        input  done,
        input  result
    );
endinterface

// File: rtl/sar_searcher.sv
// ---------------------------------------------------------------------------
// sar_searcher
// Finds an unknown two's-complement target by successive approximation,
// one bit per cycle, MSB first, using an external signed less-than
// comparator wired as lt_in = (target < guess).
//
// Ports:
//   clk    : single clock, all state updates on rising edge
//   reset  : synchronous, active-high reset
//   bus    : sar_searcher_if.master (start, lt_in, guess, busy, done, result)
//
// The search runs on an offset-binary code so that plain bit-by-bit binary
// search ordering matches signed ordering; guess/result are the code with
// its MSB flipped back to two's complement.
// ---------------------------------------------------------------------------
module sar_searcher #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    sar_searcher_if.master bus
);

    localparam int IDXW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRIAL,
        S_DONE
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] code,  code_d;
    logic [IDXW-1:0]  idx,   idx_d;
    logic [WIDTH-1:0] result_q, result_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational process.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            code     <= '0;
            idx      <= '0;
            result_q <= '0;
        end else begin
            state    <= state_d;
            code     <= code_d;
            idx      <= idx_d;
            result_q <= result_d;
        end
    end

    // NOTE: every variable gets its hold value first, so no path through the
    // case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state;
        code_d   = code;
        idx_d    = idx;
        result_d = result_q;

        unique case (state)
            S_IDLE: begin
                // start is only looked at here; busy/done cycles ignore it
                if (bus.start) begin
                    code_d  = MSB_MASK;   // offset-binary midpoint == signed 0
                    idx_d   = IDX_TOP;
                    state_d = S_TRIAL;
                end
            end

            S_TRIAL: begin
                // lt_in answers for the guess driven this very cycle
                if (bus.lt_in) begin
                    code_d[idx] = 1'b0;
                end
                if (idx != '0) begin
                    code_d[idx - 1'b1] = 1'b1;
                    idx_d              = idx - 1'b1;
                end else begin
                    result_d = code_d ^ MSB_MASK;
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.guess  = (state == S_TRIAL) ? (code ^ MSB_MASK) : '0;
    assign bus.busy   = (state == S_TRIAL);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_sar_searcher.sv
// ---------------------------------------------------------------------------
// tb_sar_searcher
// Bench for sar_searcher. A comparator model drives lt_in from a bench-held
// target. A cycle-level reference model tracks the search in signed
// arithmetic (guess starts at 0, moves by a halving step, final correction
// of one) and a compare process checks every output on every cycle after
// reset. Directed sequences also pin guesses/results to literal values.
// ---------------------------------------------------------------------------
module tb_sar_searcher;

    localparam int WIDTH = 4;

    logic clk;
    logic reset;
    logic signed [WIDTH-1:0] target;

    sar_searcher_if #(.WIDTH(WIDTH)) bus ();

    sar_searcher #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // comparator responder: A = target, B = guess
    assign bus.lt_in = (target < $signed(bus.guess));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (signed binary search) ----------------
    int m_left = 0;   // trial cycles still to present; 0 = not searching
    bit m_done = 1'b0;
    int m_g    = 0;
    int m_step = 0;
    int m_res  = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_g    = 0;
            m_res  = 0;
        end else if (m_left > 0) begin
            if (m_left == 1) begin
                m_res  = (int'(target) < m_g) ? m_g - 1 : m_g;
                m_left = 0;
                m_done = 1'b1;
                m_g    = 0;
            end else begin
                m_g    = (int'(target) < m_g) ? m_g - m_step : m_g + m_step;
                m_step = m_step / 2;
                m_left = m_left - 1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (bus.start) begin
            m_left = WIDTH;
            m_g    = 0;
            m_step = 1 << (WIDTH - 2);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",   int'(bus.busy), int'(m_left > 0));
            check("done",   int'(bus.done), int'(m_done));
            check("guess",  int'($signed(bus.guess)), (m_left > 0) ? m_g : 0);
            check("result", int'($signed(bus.result)), m_res);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_search(input int tgt, input int g0, input int g1,
                              input int g2, input int g3, input int exp_res,
                              input bit pulse_mid);
        int exp_g [WIDTH];
        exp_g = '{g0, g1, g2, g3};
        target = WIDTH'(tgt);
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge clk);
            check($sformatf("lit_guess[%0d] tgt %0d", k, tgt),
                  int'($signed(bus.guess)), exp_g[k]);
            check("lit_busy", int'(bus.busy), 1);
            @(posedge clk); #1;
            bus.start = (pulse_mid && k == 1);
        end
        bus.start = 1'b0;
        @(negedge clk);
        check($sformatf("lit_done tgt %0d", tgt), int'(bus.done), 1);
        check($sformatf("lit_result tgt %0d", tgt), int'($signed(bus.result)), exp_res);
        @(negedge clk);
        check("lit_done_once", int'(bus.done), 0);
        check("lit_result_held", int'($signed(bus.result)), exp_res);
    endtask

    initial begin
        int cnt;
        reset     = 1'b1;
        bus.start = 1'b0;
        target    = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        // idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_busy",  int'(bus.busy), 0);
            check("idle_done",  int'(bus.done), 0);
            check("idle_guess", int'(bus.guess), 0);
            check("idle_result", int'(bus.result), 0);
        end

        run_search( 3, 0,  4,  2,  3,  3, 1'b0);
        run_search(-8, 0, -4, -6, -7, -8, 1'b0);
        run_search( 7, 0,  4,  6,  7,  7, 1'b0);
        run_search(-1, 0, -4, -2, -1, -1, 1'b1);

        // reset during the second trial cycle discards the held result
        target = 4'sd3;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy",   int'(bus.busy), 0);
        check("rst_guess",  int'(bus.guess), 0);
        check("rst_result", int'(bus.result), 0);
        check("rst_done",   int'(bus.done), 0);

        run_search( 5, 0,  4,  6,  5,  5, 1'b0);

        // all targets back to back, start in the cycle after each done
        @(posedge clk); #1;
        for (int t = -(1 << (WIDTH-1)); t < (1 << (WIDTH-1)); t++) begin
            target    = WIDTH'(t);
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            cnt = 1;
            while (1) begin
                @(negedge clk);
                if (bus.done || cnt > 20) break;
                @(posedge clk); #1;
                cnt++;
            end
            check($sformatf("span tgt %0d", t), cnt, WIDTH + 1);
            check($sformatf("exh_result tgt %0d", t), int'($signed(bus.result)), t);
            @(posedge clk); #1;
        end

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_searcher.md
Name: sar_searcher

Overview:
- Initiator-side partner of the team's 4-bit signed less-than comparator.
- Finds an unknown two's-complement target value by successive approximation. Each cycle it presents a trial value and consumes the comparator's single-bit answer.
- Comparator wiring at integration: A = target, B = guess, so lt_in = (target < guess), signed.
- Used in the P1 datapath demo to exercise the comparator as a responder. Parameterised for wider operands.

Parameters:
- WIDTH, 4, operand width in bits; signed two's complement; must be >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new search; sampled only in IDLE.
- lt_in  input  1  comparator answer for the current guess: 1 = target < guess (signed).
- guess  output  WIDTH  trial value driven to comparator B; combinational from state.
- busy  output  1  high while searching (TRIAL state).
- done  output  1  one-cycle pulse when result becomes valid.
- result  output  WIDTH  found target value, signed; held until next accepted start.

Behaviour:
- Reset values:
  - state = IDLE; code = 0; bit index = 0.
  - guess = 0; busy = 0; done = 0; result = 0.
- Internal representation:
  - code is a WIDTH-bit offset-binary register.
  - guess = code XOR (1 << (WIDTH-1)) while in TRIAL; guess = 0 otherwise.
- States: IDLE, TRIAL, DONE.
- IDLE:
  - On start = 1: code <= 1 << (WIDTH-1), so guess = 0; idx <= WIDTH-1; go to TRIAL.
  - On start = 0: stay in IDLE.
- TRIAL (exactly WIDTH cycles):
  - Each cycle, lt_in is sampled against the guess driven in that same cycle. The comparator path is purely combinational; no extra wait cycle.
  - If lt_in = 1, clear code[idx]; if lt_in = 0, keep code[idx].
  - If idx > 0: set code[idx-1] and decrement idx.
  - If idx = 0: result <= final code XOR MSB mask; go to DONE.
- DONE (1 cycle):
  - done = 1, busy = 0; go to IDLE.
  - start in DONE is ignored and not queued.
- Latency: start accepted at cycle N; guesses are presented in cycles N+1 .. N+WIDTH; done = 1 in cycle N+WIDTH+1.
- start while busy or in DONE: ignored; the search in progress is not disturbed.
- Result semantics: result is the largest signed value v with v <= target, which equals the target for any target in range.
  - Range: -2^(WIDTH-1) .. 2^(WIDTH-1)-1.
  - No overflow or wrap is possible; the search never leaves the signed range.
- result is updated only on the TRIAL->DONE transition. It stays stable through IDLE and the next search until that search completes.
- Reset mid-search, in any state: next cycle is IDLE with all outputs at their reset values. The previous result is discarded (0).
- lt_in is a don't-care outside TRIAL.

Test Plan:
- After reset, hold start = 0 for 5 cycles -> busy = 0, done = 0, guess = 0, result = 0 throughout.
- Target 3 (comparator model) -> guesses 0, 4, 2, 3 in cycles 1-4; lt_in = 0, 1, 0, 0; done pulse in cycle 5; result = 4'b0011.
- Target -8 -> guesses 0, -4, -6, -7; lt_in all 1; result = 4'b1000. Target 7 -> guesses 0, 4, 6, 7; lt_in all 0; result = 4'b0111.
- Target -1 -> guesses 0, -4, -2, -1; result = 4'b1111. Then pulse start again during the search -> ignored; done fires exactly once, in cycle 5.
- Assert reset in TRIAL cycle 2 -> next cycle IDLE, busy = 0, guess = 0, result = 0. A new start then completes normally for target 5 -> result = 4'b0101.
- Exhaustive check: all 16 targets back-to-back, with start asserted in the cycle after each done -> every result equals its target; each search spans exactly 6 cycles from start to done.
